// File: rtl/iob_axi_ram_responder_if.sv
// AXI4 bus between the external-memory master and iob_axi_ram_responder.
// Member names keep the responder-side _i/_o direction suffixes.
interface iob_axi_ram_responder_if #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32
);
    logic [AXI_ID_W-1:0]     axi_awid_i;
    logic [AXI_ADDR_W-1:0]   axi_awaddr_i;
    logic [AXI_LEN_W-1:0]    axi_awlen_i;
    logic [2:0]              axi_awsize_i;
    logic [1:0]              axi_awburst_i;
    logic                    axi_awlock_i;
    logic [3:0]              axi_awcache_i;
    logic [2:0]              axi_awprot_i;
    logic [3:0]              axi_awqos_i;
    logic                    axi_awvalid_i;
    logic                    axi_awready_o;
    logic [AXI_DATA_W-1:0]   axi_wdata_i;
    logic [AXI_DATA_W/8-1:0] axi_wstrb_i;
    logic                    axi_wlast_i;
    logic                    axi_wvalid_i;
    logic                    axi_wready_o;
    logic [AXI_ID_W-1:0]     axi_bid_o;
    logic [1:0]              axi_bresp_o;
    logic                    axi_bvalid_o;
    logic                    axi_bready_i;
    logic [AXI_ID_W-1:0]     axi_arid_i;
    logic [AXI_ADDR_W-1:0]   axi_araddr_i;
    logic [AXI_LEN_W-1:0]    axi_arlen_i;
    logic [2:0]              axi_arsize_i;
    logic [1:0]              axi_arburst_i;
    logic                    axi_arlock_i;
    logic [3:0]              axi_arcache_i;
    logic [2:0]              axi_arprot_i;
    logic [3:0]              axi_arqos_i;
    logic                    axi_arvalid_i;
    logic                    axi_arready_o;
    logic [AXI_ID_W-1:0]     axi_rid_o;
    logic [AXI_DATA_W-1:0]   axi_rdata_o;
    logic [1:0]              axi_rresp_o;
    logic                    axi_rlast_o;
    logic                    axi_rvalid_o;
    logic                    axi_rready_i;

    modport slave (
        input  axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i,
               axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i, axi_awvalid_i,
               axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i, axi_bready_i,
               axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
               axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i, axi_arvalid_i,
               axi_rready_i,
        output axi_awready_o, axi_wready_o, axi_bid_o, axi_bresp_o, axi_bvalid_o,
               axi_arready_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o,
               axi_rvalid_o
    );

    modport master (
        output axi_awid_i, axi_awaddr_i, axi_awlen_i, axi_awsize_i, axi_awburst_i,
               axi_awlock_i, axi_awcache_i, axi_awprot_i, axi_awqos_i, axi_awvalid_i,
               axi_wdata_i, axi_wstrb_i, axi_wlast_i, axi_wvalid_i, axi_bready_i,
               axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
               axi_arlock_i, axi_arcache_i, axi_arprot_i, axi_arqos_i, axi_arvalid_i,
               axi_rready_i,
        input  axi_awready_o, axi_wready_o, axi_bid_o, axi_bresp_o, axi_bvalid_o,
               axi_arready_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o,
               axi_rvalid_o
    );
endinterface

// File: rtl/iob_axi_ram_responder.sv
// AXI4 responder backed by an internal dual-port RAM: one write and one read burst in flight.
// Optional macro IOB_AXI_RAM_RANGE_CHECK_EN flags bursts that run past the RAM with SLVERR.
module iob_axi_ram_responder #(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int MEM_ADDR_W = 16
) (
    input logic                    clk_i,
    input logic                    rst_i,
    iob_axi_ram_responder_if.slave axi
);
    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int DEPTH  = 2 ** MEM_ADDR_W;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_t;

    w_state_t              w_state_r;
    r_state_t              r_state_r;
    logic [MEM_ADDR_W-1:0] wr_idx_r;
    logic [MEM_ADDR_W-1:0] rd_idx_r;
    logic [AXI_LEN_W-1:0]  wr_len_r;
    logic [AXI_LEN_W-1:0]  wr_cnt_r;
    logic [AXI_LEN_W-1:0]  rd_len_r;
    logic [AXI_LEN_W-1:0]  rd_cnt_r;
    logic                  wr_fixed_r;
    logic                  rd_fixed_r;
    logic                  wr_err_r;
    logic                  wr_oor_r;
    logic                  rd_oor_r;

    logic                  awready_r;
    logic                  wready_r;
    logic                  bvalid_r;
    logic [AXI_ID_W-1:0]   bid_r;
    logic [1:0]            bresp_r;
    logic                  arready_r;
    logic                  rvalid_r;
    logic                  rlast_r;
    logic [AXI_ID_W-1:0]   rid_r;
    logic [1:0]            rresp_r;
    logic [AXI_DATA_W-1:0] rdata_r;

    logic [AXI_DATA_W-1:0] mem_r [DEPTH];

    logic                  aw_oor_s;
    logic                  ar_oor_s;
    logic                  wr_last_s;
    logic                  wr_store_s;
    logic                  unused_s;

    function automatic logic [MEM_ADDR_W-1:0] word_idx_f(input logic [AXI_ADDR_W-1:0] addr);
        return MEM_ADDR_W'(addr >> OFF);
    endfunction

`ifdef IOB_AXI_RAM_RANGE_CHECK_EN
    localparam int EXT_W = AXI_ADDR_W + AXI_LEN_W + 1;

    // Untruncated start and end word indices must both land inside the RAM.
    function automatic logic range_bad_f(input logic [AXI_ADDR_W-1:0] addr,
                                         input logic [AXI_LEN_W-1:0]  len);
        logic [EXT_W-1:0] start_v;
        logic [EXT_W-1:0] end_v;
        logic [EXT_W-1:0] lim_v;
        start_v = EXT_W'(addr >> OFF);
        end_v   = start_v + EXT_W'(len);
        lim_v   = EXT_W'({MEM_ADDR_W{1'b1}});
        return (start_v > lim_v) || (end_v > lim_v);
    endfunction

    assign aw_oor_s = range_bad_f(axi.axi_awaddr_i, axi.axi_awlen_i);
    assign ar_oor_s = range_bad_f(axi.axi_araddr_i, axi.axi_arlen_i);
`else
    assign aw_oor_s = 1'b0;
    assign ar_oor_s = 1'b0;
`endif

    assign wr_last_s  = (wr_cnt_r == wr_len_r);
    assign wr_store_s = (w_state_r == W_DATA) && axi.axi_wvalid_i && !wr_oor_r && !rst_i;

    assign unused_s = ^{axi.axi_awsize_i, axi.axi_awlock_i, axi.axi_awcache_i, axi.axi_awprot_i,
                        axi.axi_awqos_i, axi.axi_arsize_i, axi.axi_arlock_i, axi.axi_arcache_i,
                        axi.axi_arprot_i, axi.axi_arqos_i, axi.axi_awaddr_i, axi.axi_araddr_i};

    assign axi.axi_awready_o = awready_r;
    assign axi.axi_wready_o  = wready_r;
    assign axi.axi_bvalid_o  = bvalid_r;
    assign axi.axi_bid_o     = bid_r;
    assign axi.axi_bresp_o   = bresp_r;
    assign axi.axi_arready_o = arready_r;
    assign axi.axi_rvalid_o  = rvalid_r;
    assign axi.axi_rlast_o   = rlast_r;
    assign axi.axi_rid_o     = rid_r;
    assign axi.axi_rresp_o   = rresp_r;
    assign axi.axi_rdata_o   = rdata_r;

    // RAM write port with per-byte strobes
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (wr_store_s && axi.axi_wstrb_i[b]) begin
                mem_r[wr_idx_r][b*8 +: 8] <= axi.axi_wdata_i[b*8 +: 8];
            end
        end
    end

    // Write channel FSM: AW -> W beats -> B
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_r  <= W_IDLE;
            awready_r  <= 1'b1;
            wready_r   <= 1'b0;
            bvalid_r   <= 1'b0;
            bid_r      <= '0;
            bresp_r    <= 2'b00;
            wr_idx_r   <= '0;
            wr_len_r   <= '0;
            wr_cnt_r   <= '0;
            wr_fixed_r <= 1'b0;
            wr_err_r   <= 1'b0;
            wr_oor_r   <= 1'b0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (axi.axi_awvalid_i && awready_r) begin
                        bid_r      <= axi.axi_awid_i;
                        wr_idx_r   <= word_idx_f(axi.axi_awaddr_i);
                        wr_len_r   <= axi.axi_awlen_i;
                        wr_cnt_r   <= '0;
                        wr_fixed_r <= (axi.axi_awburst_i == 2'b00);
                        wr_err_r   <= 1'b0;
                        wr_oor_r   <= aw_oor_s;
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b1;
                        w_state_r  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (axi.axi_wvalid_i && wready_r) begin
                        if (wr_last_s) begin
                            // The final beat's own wlast still has to be folded into bresp.
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= (wr_err_r || !axi.axi_wlast_i || wr_oor_r) ? 2'b10 : 2'b00;
                            w_state_r <= W_RESP;
                        end else begin
                            wr_err_r <= wr_err_r | axi.axi_wlast_i;
                            wr_cnt_r <= wr_cnt_r + AXI_LEN_W'(1);
                            if (!wr_fixed_r) begin
                                wr_idx_r <= wr_idx_r + MEM_ADDR_W'(1);
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (axi.axi_bready_i) begin
                        bvalid_r  <= 1'b0;
                        awready_r <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                end
            endcase
        end
    end

    // Read channel FSM: AR -> (fetch, data) per beat; RAM read is registered into rdata
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_r  <= R_IDLE;
            arready_r  <= 1'b1;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            rid_r      <= '0;
            rresp_r    <= 2'b00;
            rdata_r    <= '0;
            rd_idx_r   <= '0;
            rd_len_r   <= '0;
            rd_cnt_r   <= '0;
            rd_fixed_r <= 1'b0;
            rd_oor_r   <= 1'b0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (axi.axi_arvalid_i && arready_r) begin
                        rid_r      <= axi.axi_arid_i;
                        rd_idx_r   <= word_idx_f(axi.axi_araddr_i);
                        rd_len_r   <= axi.axi_arlen_i;
                        rd_cnt_r   <= '0;
                        rd_fixed_r <= (axi.axi_arburst_i == 2'b00);
                        rd_oor_r   <= ar_oor_s;
                        arready_r  <= 1'b0;
                        r_state_r  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    rdata_r   <= rd_oor_r ? '0 : mem_r[rd_idx_r];
                    rresp_r   <= rd_oor_r ? 2'b10 : 2'b00;
                    rlast_r   <= (rd_cnt_r == rd_len_r);
                    rvalid_r  <= 1'b1;
                    r_state_r <= R_DATA;
                end
                R_DATA: begin
                    if (axi.axi_rready_i) begin
                        rvalid_r <= 1'b0;
                        if (rlast_r) begin
                            rlast_r   <= 1'b0;
                            arready_r <= 1'b1;
                            r_state_r <= R_IDLE;
                        end else begin
                            rd_cnt_r  <= rd_cnt_r + AXI_LEN_W'(1);
                            if (!rd_fixed_r) begin
                                rd_idx_r <= rd_idx_r + MEM_ADDR_W'(1);
                            end
                            r_state_r <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    arready_r <= 1'b1;
                    rvalid_r  <= 1'b0;
                    rlast_r   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iob_axi_ram_responder.sv
// Directed self-checking bench for iob_axi_ram_responder; honours IOB_AXI_RAM_RANGE_CHECK_EN.
module tb_iob_axi_ram_responder;
    logic clk_i = 1'b0;
    logic rst_i;
    int   errors = 0;
    int   checks = 0;

    iob_axi_ram_responder_if axi ();

    iob_axi_ram_responder dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .axi   (axi)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic aw_send(input logic [23:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        axi.axi_awaddr_i  = addr;
        axi.axi_awlen_i   = len;
        axi.axi_awburst_i = burst;
        axi.axi_awid_i    = id;
        axi.axi_awvalid_i = 1'b1;
        for (int n = 0; n < 50 && axi.axi_awready_o !== 1'b1; n++) step();
        chk("awready", {63'd0, axi.axi_awready_o}, 64'd1);
        step();
        axi.axi_awvalid_i = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        axi.axi_wdata_i  = data;
        axi.axi_wstrb_i  = strb;
        axi.axi_wlast_i  = last;
        axi.axi_wvalid_i = 1'b1;
        for (int n = 0; n < 50 && axi.axi_wready_o !== 1'b1; n++) step();
        chk("wready", {63'd0, axi.axi_wready_o}, 64'd1);
        step();
        axi.axi_wvalid_i = 1'b0;
    endtask

    task automatic b_take(input string tag, input logic [3:0] id, input logic [1:0] resp);
        axi.axi_bready_i = 1'b1;
        for (int n = 0; n < 50 && axi.axi_bvalid_o !== 1'b1; n++) step();
        chk({tag, "_bvalid"}, {63'd0, axi.axi_bvalid_o}, 64'd1);
        chk({tag, "_bid"}, {60'd0, axi.axi_bid_o}, {60'd0, id});
        chk({tag, "_bresp"}, {62'd0, axi.axi_bresp_o}, {62'd0, resp});
        step();
        axi.axi_bready_i = 1'b0;
    endtask

    task automatic write_incr(input logic [23:0] addr, input logic [7:0] len,
                              input logic [3:0] id, input logic [31:0] base);
        aw_send(addr, len, 2'b01, id);
        for (int i = 0; i <= int'(len); i++) begin
            w_beat(base + 32'(i), 4'hF, (i == int'(len)));
        end
    endtask

    task automatic ar_send(input logic [23:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        axi.axi_araddr_i  = addr;
        axi.axi_arlen_i   = len;
        axi.axi_arburst_i = burst;
        axi.axi_arid_i    = id;
        axi.axi_arvalid_i = 1'b1;
        for (int n = 0; n < 50 && axi.axi_arready_o !== 1'b1; n++) step();
        chk("arready", {63'd0, axi.axi_arready_o}, 64'd1);
        step();
        axi.axi_arvalid_i = 1'b0;
    endtask

    task automatic r_take(input string tag, input logic [31:0] data, input logic last,
                          input logic [3:0] id, input logic [1:0] resp, input logic stall);
        logic [31:0] held;
        axi.axi_rready_i = !stall;
        for (int n = 0; n < 50 && axi.axi_rvalid_o !== 1'b1; n++) step();
        chk({tag, "_rvalid"}, {63'd0, axi.axi_rvalid_o}, 64'd1);
        if (stall) begin
            held = axi.axi_rdata_o;
            step();
            chk({tag, "_rvalid_hold"}, {63'd0, axi.axi_rvalid_o}, 64'd1);
            chk({tag, "_rdata_hold"}, {32'd0, axi.axi_rdata_o}, {32'd0, held});
            axi.axi_rready_i = 1'b1;
        end
        chk({tag, "_rdata"}, {32'd0, axi.axi_rdata_o}, {32'd0, data});
        chk({tag, "_rlast"}, {63'd0, axi.axi_rlast_o}, {63'd0, last});
        chk({tag, "_rid"}, {60'd0, axi.axi_rid_o}, {60'd0, id});
        chk({tag, "_rresp"}, {62'd0, axi.axi_rresp_o}, {62'd0, resp});
        step();
        axi.axi_rready_i = 1'b0;
    endtask

    initial begin
        int stray;
        rst_i = 1'b1;
        axi.axi_awid_i = 4'd0;    axi.axi_awaddr_i = 24'd0; axi.axi_awlen_i = 8'd0;
        axi.axi_awsize_i = 3'd2;  axi.axi_awburst_i = 2'b01; axi.axi_awlock_i = 1'b0;
        axi.axi_awcache_i = 4'd0; axi.axi_awprot_i = 3'd0;  axi.axi_awqos_i = 4'd0;
        axi.axi_awvalid_i = 1'b0;
        axi.axi_wdata_i = 32'd0;  axi.axi_wstrb_i = 4'h0;   axi.axi_wlast_i = 1'b0;
        axi.axi_wvalid_i = 1'b0;  axi.axi_bready_i = 1'b0;
        axi.axi_arid_i = 4'd0;    axi.axi_araddr_i = 24'd0; axi.axi_arlen_i = 8'd0;
        axi.axi_arsize_i = 3'd2;  axi.axi_arburst_i = 2'b01; axi.axi_arlock_i = 1'b0;
        axi.axi_arcache_i = 4'd0; axi.axi_arprot_i = 3'd0;  axi.axi_arqos_i = 4'd0;
        axi.axi_arvalid_i = 1'b0; axi.axi_rready_i = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_awready", {63'd0, axi.axi_awready_o}, 64'd1);
        chk("rst_arready", {63'd0, axi.axi_arready_o}, 64'd1);
        chk("rst_wready",  {63'd0, axi.axi_wready_o},  64'd0);
        chk("rst_bvalid",  {63'd0, axi.axi_bvalid_o},  64'd0);
        chk("rst_rvalid",  {63'd0, axi.axi_rvalid_o},  64'd0);
        chk("rst_rlast",   {63'd0, axi.axi_rlast_o},   64'd0);
        chk("rst_bid_bresp", {58'd0, axi.axi_bid_o, axi.axi_bresp_o}, 64'd0);
        chk("rst_rid_rresp", {58'd0, axi.axi_rid_o, axi.axi_rresp_o}, 64'd0);
        chk("rst_rdata",   {32'd0, axi.axi_rdata_o},   64'd0);
        rst_i = 1'b0;
        step();

        // Single write then read, with first-data latency
        write_incr(24'h10, 8'd0, 4'd3, 32'hDEADBEEF);
        b_take("single", 4'd3, 2'b00);
        ar_send(24'h10, 8'd0, 2'b01, 4'd3);
        chk("lat_fetch_rvalid", {63'd0, axi.axi_rvalid_o}, 64'd0);
        step();
        chk("lat_data_rvalid", {63'd0, axi.axi_rvalid_o}, 64'd1);
        r_take("single", 32'hDEADBEEF, 1'b1, 4'd3, 2'b00, 1'b0);

        // INCR burst of 8, read back with rready stalls
        write_incr(24'h100, 8'd7, 4'd1, 32'd0);
        b_take("incr", 4'd1, 2'b00);
        ar_send(24'h100, 8'd7, 2'b01, 4'd1);
        for (int i = 0; i < 8; i++) r_take("incr", 32'(i), (i == 7), 4'd1, 2'b00, 1'b1);

        // Byte strobes
        write_incr(24'h40, 8'd0, 4'd2, 32'h11223344);
        b_take("strb_a", 4'd2, 2'b00);
        aw_send(24'h40, 8'd0, 2'b01, 4'd2);
        w_beat(32'hAABBCCDD, 4'b0101, 1'b1);
        b_take("strb_b", 4'd2, 2'b00);
        ar_send(24'h40, 8'd0, 2'b01, 4'd2);
        r_take("strb", 32'h11BB33DD, 1'b1, 4'd2, 2'b00, 1'b0);

        // wlast mismatch: all four beats taken, SLVERR, wready drops after the last
        aw_send(24'h200, 8'd3, 2'b01, 4'd4);
        w_beat(32'hD0, 4'hF, 1'b0);
        w_beat(32'hD1, 4'hF, 1'b1);
        w_beat(32'hD2, 4'hF, 1'b0);
        w_beat(32'hD3, 4'hF, 1'b0);
        chk("mismatch_wready_drop", {63'd0, axi.axi_wready_o}, 64'd0);
        b_take("mismatch", 4'd4, 2'b10);

        // FIXED burst keeps only the final beat
        aw_send(24'h20, 8'd3, 2'b00, 4'd5);
        for (int i = 0; i < 4; i++) w_beat(32'hA0 + 32'(i), 4'hF, (i == 3));
        b_take("fixed", 4'd5, 2'b00);
        ar_send(24'h20, 8'd0, 2'b01, 4'd5);
        r_take("fixed", 32'hA3, 1'b1, 4'd5, 2'b00, 1'b0);

        // Concurrent write and read bursts in disjoint regions
        write_incr(24'h800, 8'd15, 4'd5, 32'h1000);
        b_take("preload", 4'd5, 2'b00);
        fork
            begin
                write_incr(24'h400, 8'd15, 4'd6, 32'h2000);
                b_take("conc_w", 4'd6, 2'b00);
            end
            begin
                ar_send(24'h800, 8'd15, 2'b01, 4'd7);
                for (int i = 0; i < 16; i++) r_take("conc_r", 32'h1000 + 32'(i), (i == 15), 4'd7, 2'b00, 1'b0);
            end
        join
        ar_send(24'h400, 8'd15, 2'b01, 4'd6);
        for (int i = 0; i < 16; i++) r_take("conc_chk", 32'h2000 + 32'(i), (i == 15), 4'd6, 2'b00, 1'b0);

        // Reset during beat 5 of a read
        ar_send(24'h800, 8'd15, 2'b01, 4'd8);
        for (int i = 0; i < 5; i++) r_take("pre_rst", 32'h1000 + 32'(i), 1'b0, 4'd8, 2'b00, 1'b0);
        for (int n = 0; n < 50 && axi.axi_rvalid_o !== 1'b1; n++) step();
        chk("beat5_rvalid", {63'd0, axi.axi_rvalid_o}, 64'd1);
        rst_i = 1'b1;
        step();
        chk("mid_rst_rvalid",  {63'd0, axi.axi_rvalid_o},  64'd0);
        chk("mid_rst_arready", {63'd0, axi.axi_arready_o}, 64'd1);
        chk("mid_rst_rlast",   {63'd0, axi.axi_rlast_o},   64'd0);
        rst_i = 1'b0;
        axi.axi_rready_i = 1'b1;
        stray = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (axi.axi_rvalid_o !== 1'b0) stray++;
        end
        axi.axi_rready_i = 1'b0;
        chk("post_rst_no_beats", 64'(stray), 64'd0);
        ar_send(24'h40, 8'd0, 2'b01, 4'd9);
        r_take("ram_kept", 32'h11BB33DD, 1'b1, 4'd9, 2'b00, 1'b0);

        // Burst running past the last RAM word
        write_incr(24'h3FFFC, 8'd0, 4'd9, 32'h5555AAAA);
        b_take("last_word", 4'd9, 2'b00);
        write_incr(24'h0, 8'd0, 4'd9, 32'h12345678);
        b_take("word0", 4'd9, 2'b00);
        ar_send(24'h3FFFC, 8'd1, 2'b01, 4'd10);
`ifdef IOB_AXI_RAM_RANGE_CHECK_EN
        r_take("oor_b0", 32'h0, 1'b0, 4'd10, 2'b10, 1'b0);
        r_take("oor_b1", 32'h0, 1'b1, 4'd10, 2'b10, 1'b0);
        write_incr(24'h3FFFC, 8'd1, 4'd11, 32'h77770000);
        b_take("oor_w", 4'd11, 2'b10);
        ar_send(24'h3FFFC, 8'd0, 2'b01, 4'd11);
        r_take("oor_w_not_stored", 32'h5555AAAA, 1'b1, 4'd11, 2'b00, 1'b0);
`else
        r_take("wrap_b0", 32'h5555AAAA, 1'b0, 4'd10, 2'b00, 1'b0);
        r_take("wrap_b1", 32'h12345678, 1'b1, 4'd10, 2'b00, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
